// File: rtl/systolic_array_ctrl.sv
// systolic_array_ctrl: run sequencer for an N x N systolic array tile, configured over an
// Avalon-MM CSR slave. A run walks CLEAR -> FEED -> FLUSH -> DRAIN -> DONE, then returns to IDLE.
//
// Ports:
//   clk, reset_n            system clock, asynchronous active-low reset
//   avs_address/write/      CSR slave: 0 CTRL, 1 K_LEN, 2 STATUS, 3 CYCLES
//   avs_writedata/read/
//   avs_readdata            read data, registered, latency 1
//   irq                     level interrupt, DONE & IRQ_EN
//   array_clear             zero PE accumulators (CLEAR phase)
//   array_feed_en[N]        per-row/column operand injection enable (FEED phase)
//   array_step              feed-phase cycle index c
//   array_drain             result drain strobe (DRAIN phase)
//   array_drain_row         row being drained
module systolic_array_ctrl #(
  parameter int unsigned N     = 4,
  parameter int unsigned K_W   = 8,
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [1:0]       avs_address,
  input  logic             avs_write,
  input  logic [31:0]      avs_writedata,
  input  logic             avs_read,
  output logic [31:0]      avs_readdata,
  output logic             irq,
  output logic             array_clear,
  output logic [N-1:0]     array_feed_en,
  output logic [K_W+4:0]   array_step,
  output logic             array_drain,
  output logic [3:0]       array_drain_row
);

  localparam int unsigned SW = K_W + 5;

  typedef enum logic [2:0] {
    StIdle  = 3'd0,
    StClear = 3'd1,
    StFeed  = 3'd2,
    StFlush = 3'd3,
    StDrain = 3'd4,
    StDone  = 3'd5
  } state_e;

  state_e           r_state, w_state_next;
  logic [SW-1:0]    r_cnt, w_cnt_next;
  logic [K_W-1:0]   r_k_len, r_k_run;
  logic             r_irq_en, r_done, r_err, r_irq;
  logic [CNT_W-1:0] r_run_cnt, r_cycles;
  logic [31:0]      r_readdata;

  logic             w_ctrl_wr, w_klen_wr, w_start_req, w_start, w_busy;
  logic             w_feed_last, w_n_last;
  logic [SW-1:0]    w_k_ext;
  logic             w_done_next, w_err_next, w_irq_en_next;
  logic [31:0]      w_rd_mux;
  logic             w_unused_wdata;

  assign w_ctrl_wr   = avs_write && (avs_address == 2'd0);
  assign w_klen_wr   = avs_write && (avs_address == 2'd1);
  assign w_start_req = w_ctrl_wr && avs_writedata[0];
  assign w_busy      = (r_state != StIdle);
  assign w_start     = w_start_req && !w_busy && (r_k_len != '0);

  // K is the value captured at START, so K_LEN writes cannot disturb a run.
  assign w_k_ext     = SW'(r_k_run);
  assign w_feed_last = (r_cnt == w_k_ext + SW'(N - 2));
  assign w_n_last    = (r_cnt == SW'(N - 1));

  assign w_unused_wdata = ^avs_writedata[31:K_W];

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= StIdle;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_next;
      r_cnt   <= w_cnt_next;
    end
  end

  // Next-state logic; r_cnt is the cycle index within the current phase.
  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt + SW'(1);
    unique case (r_state)
      StIdle: begin
        w_cnt_next = '0;
        if (w_start) w_state_next = StClear;
      end
      StClear: begin
        w_cnt_next   = '0;
        w_state_next = StFeed;
      end
      StFeed: begin
        if (w_feed_last) begin
          w_cnt_next   = '0;
          w_state_next = StFlush;
        end
      end
      StFlush: begin
        if (w_n_last) begin
          w_cnt_next   = '0;
          w_state_next = StDrain;
        end
      end
      StDrain: begin
        if (w_n_last) begin
          w_cnt_next   = '0;
          w_state_next = StDone;
        end
      end
      StDone: begin
        w_cnt_next   = '0;
        w_state_next = StIdle;
      end
      default: begin
        w_cnt_next   = '0;
        w_state_next = StIdle;
      end
    endcase
  end

  // Array-facing outputs, decoded from state and phase index.
  always_comb begin
    array_clear     = 1'b0;
    array_feed_en   = '0;
    array_step      = '0;
    array_drain     = 1'b0;
    array_drain_row = '0;
    unique case (r_state)
      StClear: array_clear = 1'b1;
      StFeed: begin
        array_step = r_cnt;
        // Row r is live for c in [r, r+K-1]: this is the operand skew.
        for (int r = 0; r < N; r++) begin
          array_feed_en[r] = (r_cnt >= SW'(r)) && (r_cnt < SW'(r) + w_k_ext);
        end
      end
      StDrain: begin
        array_drain     = 1'b1;
        array_drain_row = r_cnt[3:0];
      end
      default: ;
    endcase
  end

  // CTRL/STATUS flag updates. DONE_CLR acts before START, so a rejected START in the
  // same write still leaves ERR set.
  always_comb begin
    w_done_next   = r_done;
    w_err_next    = r_err;
    w_irq_en_next = r_irq_en;
    if (w_ctrl_wr) begin
      w_irq_en_next = avs_writedata[1];
      if (avs_writedata[2]) begin
        w_done_next = 1'b0;
        w_err_next  = 1'b0;
      end
    end
    if (w_start_req && !w_start) w_err_next = 1'b1;
    if (r_state == StDone)       w_done_next = 1'b1;
  end

  always_comb begin
    w_rd_mux = '0;
    unique case (avs_address)
      2'd0: w_rd_mux = {30'b0, r_irq_en, 1'b0};
      2'd1: w_rd_mux = 32'(r_k_len);
      2'd2: w_rd_mux = {21'b0, r_state, 5'b0, r_err, r_done, w_busy};
      2'd3: w_rd_mux = 32'(r_cycles);
      default: w_rd_mux = '0;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_k_len    <= K_W'(1);
      r_k_run    <= '0;
      r_irq_en   <= 1'b0;
      r_done     <= 1'b0;
      r_err      <= 1'b0;
      r_irq      <= 1'b0;
      r_run_cnt  <= '0;
      r_cycles   <= '0;
      r_readdata <= '0;
    end else begin
      r_done   <= w_done_next;
      r_err    <= w_err_next;
      r_irq_en <= w_irq_en_next;
      // Built from next-state flags so irq drops on the same edge DONE is cleared.
      r_irq    <= w_done_next & w_irq_en_next;
      if (w_klen_wr && !w_busy) r_k_len <= avs_writedata[K_W-1:0];
      if (w_start) begin
        r_k_run   <= r_k_len;
        r_run_cnt <= '0;
      end else if (w_busy && (r_run_cnt != '1)) begin
        r_run_cnt <= r_run_cnt + CNT_W'(1);
      end
      // r_run_cnt covers CLEAR..DRAIN; add one for the DONE cycle itself.
      if (r_state == StDone) begin
        r_cycles <= (r_run_cnt == '1) ? r_run_cnt : r_run_cnt + CNT_W'(1);
      end
      if (avs_read) r_readdata <= w_rd_mux;
    end
  end

  assign avs_readdata = r_readdata;
  assign irq          = r_irq;

endmodule

// File: tb/tb_systolic_array_ctrl.sv
// Bench for systolic_array_ctrl: a run-timeline model checked every cycle plus directed vectors.
module tb_systolic_array_ctrl;
  localparam int N     = 4;
  localparam int K_W   = 8;
  localparam int CNT_W = 16;

  logic              clk = 1'b0;
  logic              reset_n = 1'b0;
  logic [1:0]        avs_address = '0;
  logic              avs_write = 1'b0;
  logic [31:0]       avs_writedata = '0;
  logic              avs_read = 1'b0;
  logic [31:0]       avs_readdata;
  logic              irq;
  logic              array_clear;
  logic [N-1:0]      array_feed_en;
  logic [K_W+4:0]    array_step;
  logic              array_drain;
  logic [3:0]        array_drain_row;

  systolic_array_ctrl #(.N(N), .K_W(K_W), .CNT_W(CNT_W)) dut (
    .clk             (clk),
    .reset_n         (reset_n),
    .avs_address     (avs_address),
    .avs_write       (avs_write),
    .avs_writedata   (avs_writedata),
    .avs_read        (avs_read),
    .avs_readdata    (avs_readdata),
    .irq             (irq),
    .array_clear     (array_clear),
    .array_feed_en   (array_feed_en),
    .array_step      (array_step),
    .array_drain     (array_drain),
    .array_drain_row (array_drain_row)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model: a run is a timeline t = 0 .. K+3N ----------------
  bit          m_active, m_irq_en, m_done, m_err, m_irq, mb_busy, mb_start;
  int          m_t, m_k, m_k_len, m_cycles;
  logic [31:0] m_rd;

  function automatic int total_of(input int k);
    return 1 + (k + N - 1) + N + N + 1;
  endfunction

  function automatic int phase_of(input int t, input int k);
    if (t == 0)               return 1;
    else if (t <= k + N - 1)  return 2;
    else if (t < k + 2 * N)   return 3;
    else if (t < k + 3 * N)   return 4;
    else                      return 5;
  endfunction

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_active = 0; m_irq_en = 0; m_done = 0; m_err = 0; m_irq = 0;
      m_t = 0; m_k = 0; m_k_len = 1; m_cycles = 0; m_rd = '0;
    end else begin
      mb_busy  = m_active;
      mb_start = 0;
      if (avs_read) begin
        case (avs_address)
          2'd0: m_rd = {30'b0, m_irq_en, 1'b0};
          2'd1: m_rd = 32'(m_k_len);
          2'd2: m_rd = {21'b0, (mb_busy ? 3'(phase_of(m_t, m_k)) : 3'd0), 5'b0,
                        m_err, m_done, mb_busy};
          default: m_rd = 32'(m_cycles);
        endcase
      end
      if (avs_write && avs_address == 2'd0) begin
        if (avs_writedata[2]) begin m_done = 0; m_err = 0; end
        m_irq_en = avs_writedata[1];
        if (avs_writedata[0]) begin
          if (!mb_busy && m_k_len != 0) mb_start = 1;
          else m_err = 1;
        end
      end
      if (avs_write && avs_address == 2'd1 && !mb_busy) m_k_len = int'(avs_writedata[K_W-1:0]);
      if (m_active) begin
        if (m_t == total_of(m_k) - 1) begin
          m_done   = 1;
          m_cycles = (total_of(m_k) > (2 ** CNT_W) - 1) ? (2 ** CNT_W) - 1 : total_of(m_k);
          m_active = 0;
        end else begin
          m_t++;
        end
      end
      if (mb_start) begin m_active = 1; m_t = 0; m_k = m_k_len; end
      m_irq = m_done && m_irq_en;
    end
  end

  // Compare process: every cycle out of reset, all outputs against the model.
  always @(negedge clk) begin
    if (reset_n) begin
      logic [N-1:0] e_en;
      int e_ph, c;
      e_en = '0;
      e_ph = m_active ? phase_of(m_t, m_k) : 0;
      c    = m_t - 1;
      if (e_ph == 2) begin
        for (int r = 0; r < N; r++) e_en[r] = (c >= r) && (c < r + m_k);
      end
      chk("m_clear",   32'(array_clear),     32'(e_ph == 1));
      chk("m_feed_en", 32'(array_feed_en),   32'(e_en));
      chk("m_step",    32'(array_step),      (e_ph == 2) ? 32'(c) : 32'd0);
      chk("m_drain",   32'(array_drain),     32'(e_ph == 4));
      chk("m_row",     32'(array_drain_row), (e_ph == 4) ? 32'(m_t - m_k - 2 * N) : 32'd0);
      chk("m_irq",     32'(irq),             32'(m_irq));
      chk("m_rdata",   avs_readdata,         m_rd);
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    avs_address = a; avs_writedata = d; avs_write = 1'b1;
    tick();
    avs_write = 1'b0;
  endtask

  task automatic rd(input logic [1:0] a, input logic [31:0] exp, input string name);
    avs_address = a; avs_read = 1'b1;
    tick();
    avs_read = 1'b0;
    @(negedge clk);
    chk(name, avs_readdata, exp);
  endtask

  task automatic wait_idle();
    bit idle = 0;
    for (int i = 0; i < 100 && !idle; i++) begin
      avs_address = 2'd2; avs_read = 1'b1;
      tick();
      avs_read = 1'b0;
      @(negedge clk);
      if (avs_readdata[0] == 1'b0) idle = 1;
    end
    chk("wait_idle", 32'(idle), 32'd1);
  endtask

  logic [3:0] pat4[7];
  logic [3:0] pat1[4];

  initial begin
    pat4 = '{4'b0001, 4'b0011, 4'b0111, 4'b1111, 4'b1110, 4'b1100, 4'b1000};
    pat1 = '{4'b0001, 4'b0010, 4'b0100, 4'b1000};
    repeat (3) @(posedge clk);
    @(negedge clk); #1 reset_n = 1'b1;

    // Reset state
    @(negedge clk);
    chk("rst_outs", {26'b0, array_clear, array_drain, array_feed_en}, 32'd0);
    chk("rst_irq", 32'(irq), 32'd0);
    rd(2'd2, 32'h0, "rst_status");
    rd(2'd1, 32'h1, "rst_klen");
    rd(2'd3, 32'h0, "rst_cycles");

    // K=4 run with IRQ_EN
    wr(2'd1, 32'd4);
    wr(2'd0, 32'h3);
    @(negedge clk);
    chk("k4_clear", 32'(array_clear), 32'd1);
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      chk("k4_feed_en", 32'(array_feed_en), 32'(pat4[i]));
      chk("k4_step", 32'(array_step), 32'(i));
    end
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("k4_flush", {30'b0, array_drain, |array_feed_en}, 32'd0);
    end
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("k4_drain", 32'(array_drain), 32'd1);
      chk("k4_row", 32'(array_drain_row), 32'(i));
    end
    repeat (2) @(negedge clk);
    rd(2'd2, 32'h002, "k4_status");
    rd(2'd3, 32'd17, "k4_cycles");
    chk("k4_irq", 32'(irq), 32'd1);

    // DONE_CLR
    wr(2'd0, 32'h4);
    @(negedge clk);
    chk("clr_irq", 32'(irq), 32'd0);
    rd(2'd2, 32'h0, "clr_status");

    // START during FEED and K_LEN write mid-run
    wr(2'd0, 32'h1);
    tick();
    wr(2'd0, 32'h1);
    wr(2'd1, 32'd9);
    wait_idle();
    rd(2'd3, 32'd17, "busy_cycles");
    rd(2'd2, 32'h006, "busy_status");
    rd(2'd1, 32'd4, "busy_klen");

    // K_LEN=0 START
    wr(2'd0, 32'h4);
    wr(2'd1, 32'd0);
    wr(2'd0, 32'h1);
    rd(2'd2, 32'h004, "k0_status");
    repeat (3) begin
      @(negedge clk);
      chk("k0_outs", {26'b0, array_clear, array_drain, array_feed_en}, 32'd0);
    end

    // K=1 run
    wr(2'd0, 32'h4);
    wr(2'd1, 32'd1);
    wr(2'd0, 32'h1);
    @(negedge clk);
    chk("k1_clear", 32'(array_clear), 32'd1);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("k1_feed_en", 32'(array_feed_en), 32'(pat1[i]));
    end
    wait_idle();
    rd(2'd3, 32'd14, "k1_cycles");

    // Reset during DRAIN row 2
    wr(2'd1, 32'd4);
    wr(2'd0, 32'h1);
    @(negedge clk);
    repeat (14) @(negedge clk);
    chk("rr_row2", {27'b0, array_drain, array_drain_row}, 32'h12);
    #1 reset_n = 1'b0;
    #1;
    chk("rr_outs", {26'b0, array_clear, array_drain, array_feed_en}, 32'd0);
    chk("rr_misc", {18'b0, irq, array_step}, 32'd0);
    chk("rr_row", 32'(array_drain_row), 32'd0);
    chk("rr_rdata", avs_readdata, 32'd0);
    @(negedge clk); #1 reset_n = 1'b1;
    rd(2'd2, 32'h0, "rr_status");
    rd(2'd1, 32'd1, "rr_klen");
    wr(2'd0, 32'h1);
    wait_idle();
    rd(2'd3, 32'd14, "rr_cycles");
    rd(2'd2, 32'h002, "rr_status2");

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

endmodule
